// File: rtl/gf2m_binary_inverter.sv
// GF(2^M) multiplicative inverter (polynomial basis, binary extended Euclid).
// Optional macro GF_INV_CYCLES_EN adds a 'cycles' output with the RUN-cycle count.
module gf2m_binary_inverter #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B,
  localparam int        CW   = $clog2(4*M+4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [M-1:0]  a,
  output logic          busy,
  output logic          done,
  output logic          err,
`ifdef GF_INV_CYCLES_EN
  output logic [CW-1:0] cycles,
`endif
  output logic [M-1:0]  inv
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  localparam logic [M:0]   ONE_W = {{M{1'b0}}, 1'b1};
  localparam logic [M-1:0] ONE_G = {{(M-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [M:0]   u_q, u_d, v_q, v_d;
  logic [M-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [M-1:0] inv_q, inv_d;
  logic         err_q, err_d;
`ifdef GF_INV_CYCLES_EN
  logic [CW-1:0] cnt_q, cnt_d, cycles_q, cycles_d;
`endif

  // Divide a g-register by x modulo POLY: add POLY first when g is odd so the
  // shift is exact; the dropped LSB is always zero.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
    logic [M:0] t;
    t = g[0] ? ({1'b0, g} ^ POLY) : {1'b0, g};
    return t[M:1];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    inv_d   = inv_q;
    err_d   = err_q;
`ifdef GF_INV_CYCLES_EN
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (a == '0) begin
            err_d   = 1'b1;
            inv_d   = '0;
            state_d = S_FIN;
`ifdef GF_INV_CYCLES_EN
            cycles_d = '0;
`endif
          end else begin
            u_d     = {1'b0, a};
            v_d     = POLY;
            g1_d    = ONE_G;
            g2_d    = '0;
            err_d   = 1'b0;
            state_d = S_RUN;
`ifdef GF_INV_CYCLES_EN
            cnt_d = '0;
`endif
          end
        end
      end

      S_RUN: begin
`ifdef GF_INV_CYCLES_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (u_q == ONE_W) begin
          inv_d   = g1_q;
          state_d = S_FIN;
`ifdef GF_INV_CYCLES_EN
          cycles_d = cnt_q + CW'(1);
`endif
        end else if (v_q == ONE_W) begin
          inv_d   = g2_q;
          state_d = S_FIN;
`ifdef GF_INV_CYCLES_EN
          cycles_d = cnt_q + CW'(1);
`endif
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = div_x(g1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = div_x(g2_q);
        end else if (u_q > v_q) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      inv_q   <= '0;
      err_q   <= 1'b0;
`ifdef GF_INV_CYCLES_EN
      cnt_q    <= '0;
      cycles_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
`ifdef GF_INV_CYCLES_EN
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
`endif
    end
  end

  // Handshake outputs depend on state only, so an X on 'a' cannot reach them.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
  assign err  = err_q;
  assign inv  = inv_q;
`ifdef GF_INV_CYCLES_EN
  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gf2m_binary_inverter.sv
// Self-checking bench for gf2m_binary_inverter: directed cases, abort/ignore
// scenarios, exhaustive sweep and randomized ops against a polynomial-arithmetic model.
module tb_gf2m_binary_inverter;
  localparam int         M    = 8;
  localparam logic [M:0] POLY = 9'h11B;
  localparam int         CW   = $clog2(4*M+4);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] a = '0;
  logic         busy, done, err;
  logic [M-1:0] inv;
`ifdef GF_INV_CYCLES_EN
  logic [CW-1:0] cycles;
`endif

  int errors = 0;
  int checks = 0;

  gf2m_binary_inverter #(.M(M), .POLY(POLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .err   (err),
`ifdef GF_INV_CYCLES_EN
    .cycles(cycles),
`endif
    .inv   (inv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Schoolbook carry-less product followed by long-division reduction by POLY.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (y[i]) p ^= ({{M{1'b0}}, x} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p ^= ((2*M)'(POLY) << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] ref_inv(input logic [M-1:0] x);
    if (x == '0) return '0;
    for (int b = 1; b < (1 << M); b++)
      if (gf_mul(x, M'(b)) == M'(1)) return M'(b);
    return '0;
  endfunction

  // Issue one start and wait (bounded) for done; lat counts cycles from the start edge.
  task automatic do_op(input logic [M-1:0] av, output int lat);
    @(negedge clk);
    a = av;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = M'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      check("busy_run", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) check("timeout", done, 1);
    else check("busy_fin", busy, 1);
  endtask

  task automatic verify(input logic [M-1:0] av);
    int lat;
    logic [M-1:0] exp;
    exp = ref_inv(av);
    do_op(av, lat);
    check("inv", inv, exp);
    check("err", err, av == '0);
    if (av != '0) check("golden_mul", gf_mul(av, inv), 1);
    check("lat_bound", lat <= 4*M+2, 1);
    if (av == '0) check("lat_zero", lat, 1);
    if (av == M'(1)) check("lat_one", lat, 2);
`ifdef GF_INV_CYCLES_EN
    check("cycles", cycles, lat - 1);
`endif
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("inv_hold", inv, exp);
    check("err_hold", err, av == '0);
  endtask

  initial begin
    int ndone;
    logic [M-1:0] got;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_inv", inv, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    verify(8'h53);
    verify(8'h01);
    verify(8'h02);
    verify(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("err_idle_hold", err, 1);
    verify(8'hFF);

    // Start while busy is ignored
    @(negedge clk);
    a = 8'h53;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    got = '0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        got = inv;
      end
    end
    check("busy_ignore_ndone", ndone, 1);
    check("busy_ignore_inv", got, ref_inv(8'h53));

    // Reset mid-RUN aborts
    @(negedge clk);
    a = 8'h53;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_inv", inv, 0);
    check("abort_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    verify(8'h53);

    // Exhaustive sweep of nonzero operands
    for (int x = 1; x < (1 << M); x++) verify(M'(x));

    // Randomized operands with random idle gaps
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      verify(M'($urandom_range(0, (1 << M) - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gf2m_binary_inverter.md
Name: gf2m_binary_inverter

Overview:
- Sequential GF(2^M) multiplicative inverter, polynomial basis, using the binary extended Euclidean algorithm.
- It performs the reverse operation of the Karatsuba multiplier tree: given a, it produces inv such that a*inv = 1 mod f(x).
- It serves as the standalone reference inverter and cross-check for the Itoh-Tsuji datapath.
- Start/done handshake. Variable latency, with a fixed upper bound.

Parameters:
- M, 8, field degree; width of a and inv.
- POLY, 9'h11B, irreducible polynomial, M+1 bits including the x^M term. Bit 0 must be 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  M  operand. Captured on the accepted start edge.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- err  output  1  high with done when a == 0. Held until the next accepted start.
- inv  output  M  result. Held from done until the next accepted start.

Behaviour:
- Reset: when rst_n=0, the block enters IDLE immediately.
  - busy=0, done=0, err=0, inv=0.
  - Internal u, v, g1, g2 are cleared.
  - Reset during RUN aborts the operation; no done is produced.
- Internal registers:
  - u, v are M+1 bits.
  - g1, g2 are M bits.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1 with a==0: go to FIN and set err=1, inv=0.
  - On start=1 with a!=0: load u=a (zero-extended), v=POLY, g1=1, g2=0; clear err; go to RUN.
  - start=0: stay in IDLE.
- RUN: exactly one action per cycle, evaluated in this priority order:
  1. u==1: inv<=g1, go to FIN.
  2. v==1: inv<=g2, go to FIN.
  3. u[0]==0: u<=u>>1. If g1[0]==0, g1<=g1>>1; otherwise g1<=(g1^POLY)>>1, truncated to M bits.
  4. v[0]==0: the same operation applied to v and g2.
  5. Otherwise, compare u and v as unsigned integers:
     - u>v: u<=u^v, g1<=g1^g2.
     - else: v<=v^u, g2<=g2^g1.
     - u==v cannot occur for a!=0.
- FIN: done=1 for exactly this cycle, then go to IDLE. busy is still 1 in FIN.
- Latency:
  - a==0: done in the 1st cycle after the start edge.
  - a==1: done in the 2nd cycle after the start edge.
  - General bound: at most 4*M+2 cycles from the start edge to done. Every XOR step is followed by a shift, and each shift reduces deg(u)+deg(v), which is at most 2M-1.
- start while busy=1 is ignored: no restart and no queueing.
- a is not required to be stable after the accepted start edge.
- inv and err keep their values through the following IDLE period until the next accepted start.
- No X may propagate from a to busy or done during IDLE with start=0.

Optional Feature:
- Macro: GF_INV_CYCLES_EN.
- When defined:
  - Adds output port cycles, width $clog2(4*M+4).
  - cycles = number of RUN cycles used by the last operation, including the terminating cycle.
  - Updated at FIN. Reset value 0. Value 0 for a==0.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- a=8'h53, start pulse -> done within 34 cycles, inv=8'hCA, err=0; busy high from the start edge through FIN.
- a=8'h01 -> done exactly 2 cycles after the start edge, inv=8'h01. a=8'h02 -> inv=8'h8D.
- a=8'h00 -> done 1 cycle after the start edge, err=1, inv=8'h00. A following a=8'hFF -> err=0, inv=8'h1C.
- Start a=8'h53, then pulse start with a=8'h02 while busy -> single done, inv=8'hCA; the second request is ignored.
- Start a=8'h53, drop rst_n for 1 cycle mid-RUN -> busy=0, done never pulses, inv=0. A restart with a=8'h53 then yields 8'hCA.
- Exhaustive sweep of all 255 nonzero a, with a golden GF multiply check: a*inv mod 9'h11B == 1, and latency ≤ 34. With GF_INV_CYCLES_EN defined, cycles equals the measured RUN count.
